// File: rtl/alu_serial_ctrl_if.sv
// Start/done handshake and operand/result bus for the bit-serial ALU sequencer.
interface alu_serial_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             carry_out;

  // Requester side: issues operations, observes completion
  modport master (
    output start, alu_ctrl, a, b,
    input  busy, done, result, zero, overflow, carry_out
  );

  // Sequencer side
  modport slave (
    input  start, alu_ctrl, a, b,
    output busy, done, result, zero, overflow, carry_out
  );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: processes one operand bit per clock, LSB first, with a
// registered carry, then applies the set/overflow correction for set-less-than.
module alu_serial_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  alu_serial_ctrl_if.slave bus
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpOr  = 4'b0001;
  localparam logic [3:0] OpAdd = 4'b0010;
  localparam logic [3:0] OpSub = 4'b0110;
  localparam logic [3:0] OpSlt = 4'b0111;
  localparam logic [3:0] OpNor = 4'b1100;

  logic [1:0]       state_q, state_d;
  logic [IdxW-1:0]  idx_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       ctrl_q;
  logic             carry_q;
  logic [WIDTH-1:0] sr_q;
  logic             set_q, ovf_q, cout_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, overflow_q, carry_out_q;

  logic             ain, bin, sum, c_next, res_bit, last_bit;
  logic             is_arith, is_slt, is_valid, ovf_bit;
  logic [WIDTH-1:0] sr_next, run_result;

  // One slice evaluation for the current bit plus op-class decode
  always_comb begin
    ain         = a_q[idx_q] ^ ctrl_q[3];
    bin         = b_q[idx_q] ^ ctrl_q[2];
    {c_next, sum} = {1'b0, ain} + {1'b0, bin} + {1'b0, carry_q};
    res_bit     = 1'b0;
    unique case (ctrl_q[1:0])
      2'b00:   res_bit = ain & bin;
      2'b01:   res_bit = ain | bin;
      2'b10:   res_bit = sum;
      default: res_bit = 1'b0;  // Less is 0 for every bit during the serial pass
    endcase
    last_bit   = (idx_q == IdxW'(WIDTH - 1));
    is_slt     = (ctrl_q == OpSlt);
    is_arith   = (ctrl_q == OpAdd) || (ctrl_q == OpSub) || is_slt;
    is_valid   = is_arith || (ctrl_q == OpAnd) || (ctrl_q == OpOr) || (ctrl_q == OpNor);
    // Carry into the MSB differs from carry out of it exactly on signed overflow
    ovf_bit    = carry_q ^ c_next;
    sr_next    = {res_bit, sr_q[WIDTH-1:1]};
    run_result = is_valid ? sr_next : '0;
  end

  // Sequencer next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (bus.start) state_d = StRun;
      StRun:   if (last_bit) state_d = is_slt ? StFix : StDone;
      StFix:   state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      ctrl_q      <= '0;
      carry_q     <= 1'b0;
      sr_q        <= '0;
      set_q       <= 1'b0;
      ovf_q       <= 1'b0;
      cout_q      <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      carry_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            a_q         <= bus.a;
            b_q         <= bus.b;
            ctrl_q      <= bus.alu_ctrl;
            idx_q       <= '0;
            sr_q        <= '0;
            carry_q     <= bus.alu_ctrl[2];  // Binvert supplies the +1 of two's complement
            set_q       <= 1'b0;
            ovf_q       <= 1'b0;
            cout_q      <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            carry_out_q <= 1'b0;
          end
        end
        StRun: begin
          carry_q <= c_next;
          idx_q   <= idx_q + 1'b1;
          sr_q    <= sr_next;
          if (last_bit) begin
            set_q  <= sum;
            ovf_q  <= ovf_bit;
            cout_q <= c_next;
            if (!is_slt) begin
              result_q    <= run_result;
              zero_q      <= (run_result == '0);
              overflow_q  <= is_arith & ovf_bit;
              carry_out_q <= is_arith & c_next;
            end
          end
        end
        StFix: begin
          // Sign of the true difference, corrected for overflow
          result_q    <= {{(WIDTH-1){1'b0}}, set_q ^ ovf_q};
          zero_q      <= ~(set_q ^ ovf_q);
          overflow_q  <= ovf_q;
          carry_out_q <= cout_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state_q == StRun) || (state_q == StFix);
  assign bus.done      = (state_q == StDone);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = overflow_q;
  assign bus.carry_out = carry_out_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Scoreboard bench for alu_serial_ctrl: issued operations push expected responses,
// a monitor pops and compares on every done pulse.
module tb_alu_serial_ctrl;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  alu_serial_ctrl_if #(.WIDTH(W)) bus ();

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] result;
    logic         zero;
    logic         ovf;
    logic         cout;
    int           lat;
    int           acc;
    string        name;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Reference: whole-word arithmetic on the operands
  function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] x,
                                 input logic [W-1:0] y);
    exp_t         e;
    logic [W:0]   s;
    logic [W-1:0] r;
    e.ovf  = 1'b0;
    e.cout = 1'b0;
    r      = '0;
    s      = '0;
    case (c)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b1100: r = ~(x | y);
      4'b0010: begin
        s      = {1'b0, x} + {1'b0, y};
        r      = s[W-1:0];
        e.cout = s[W];
        e.ovf  = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      end
      4'b0110, 4'b0111: begin
        s      = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        r      = s[W-1:0];
        e.cout = s[W];
        e.ovf  = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
        if (c == 4'b0111) r = ($signed(x) < $signed(y)) ? W'(1) : '0;
      end
      default: r = '0;
    endcase
    e.result = r;
    e.zero   = (r == '0);
    e.lat    = (c == 4'b0111) ? W + 2 : W + 1;
    e.acc    = 0;
    e.name   = "";
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus.done) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: actual done=1 at cycle %0d required no done", cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk({mon_e.name, "_result"}, 32'(bus.result), 32'(mon_e.result));
        chk({mon_e.name, "_zero"}, 32'(bus.zero), 32'(mon_e.zero));
        chk({mon_e.name, "_overflow"}, 32'(bus.overflow), 32'(mon_e.ovf));
        chk({mon_e.name, "_carry_out"}, 32'(bus.carry_out), 32'(mon_e.cout));
        chk({mon_e.name, "_busy_in_done"}, 32'(bus.busy), 32'(0));
        // cyc + 1 is the edge that closes the done cycle
        chk({mon_e.name, "_latency"}, 32'(cyc + 1 - mon_e.acc), 32'(mon_e.lat));
      end
    end
  end

  task automatic issue(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                       input string name);
    exp_t e;
    int   guard = 0;
    @(negedge clk);
    while ((bus.busy || bus.done) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_idle_timeout: actual busy=%0b required idle", name, bus.busy);
    end
    bus.start    = 1'b1;
    bus.alu_ctrl = c;
    bus.a        = x;
    bus.b        = y;
    @(posedge clk);
    #1;
    e      = model(c, x, y);
    e.acc  = cyc;
    e.name = name;
    sbq.push_back(e);
    chk({name, "_busy_after_accept"}, 32'(bus.busy), 32'(1));
    chk({name, "_outputs_cleared"},
        32'({bus.result, bus.zero, bus.overflow, bus.carry_out, bus.done}), 32'(0));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sbq.size() != 0 && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (sbq.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: actual %0d pending required 0", sbq.size());
      sbq.delete();
    end
  endtask

  logic [3:0] ops [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};

  initial begin
    #200000;
    $display("FAIL watchdog: actual time %0t required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] c;
    bus.start    = 1'b0;
    bus.alu_ctrl = '0;
    bus.a        = '0;
    bus.b        = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(bus.busy), 32'(0));
    chk("reset_done", 32'(bus.done), 32'(0));
    chk("reset_result", 32'(bus.result), 32'(0));
    chk("reset_zero", 32'(bus.zero), 32'(0));
    chk("reset_overflow", 32'(bus.overflow), 32'(0));
    chk("reset_carry_out", 32'(bus.carry_out), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    issue(4'b0010, 8'h7F, 8'h01, "add_7f_01");
    drain();
    issue(4'b0110, 8'h05, 8'h05, "sub_05_05");
    drain();
    issue(4'b0111, 8'h80, 8'h01, "slt_80_01");
    drain();
    issue(4'b0111, 8'h03, 8'h02, "slt_03_02");
    drain();
    issue(4'b1100, 8'hF0, 8'h0F, "nor_f0_0f");
    drain();
    issue(4'b0001, 8'hA0, 8'h05, "or_a0_05");
    drain();
    issue(4'b1010, 8'hFF, 8'h33, "unlisted_1010");
    drain();

    // Second start during RUN must be dropped, not queued
    issue(4'b0010, 8'h3C, 8'h41, "add_ignore_start");
    repeat (2) @(negedge clk);
    bus.start    = 1'b1;
    bus.alu_ctrl = 4'b0001;
    bus.a        = 8'h0F;
    bus.b        = 8'hF0;
    @(negedge clk);
    bus.start = 1'b0;
    drain();
    repeat (20) @(negedge clk);

    // Reset mid-RUN abandons the operation without a done pulse
    issue(4'b0110, 8'h9A, 8'h17, "sub_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    sbq.delete();
    chk("midreset_busy", 32'(bus.busy), 32'(0));
    chk("midreset_done", 32'(bus.done), 32'(0));
    chk("midreset_outputs",
        32'({bus.result, bus.zero, bus.overflow, bus.carry_out}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    issue(4'b0010, 8'hC8, 8'h64, "add_after_reset");
    drain();

    for (int i = 0; i < 60; i++) begin
      c = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : ops[$urandom_range(0, 5)];
      issue(c, W'($urandom), W'($urandom), $sformatf("rand%0d_op%0h", i, c));
    end
    drain();
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
